// File: rtl/snn_spike_decoder.sv
// Spike-count classifier: accumulates output-layer spikes over a timestep window, then scans for the argmax neuron.
// Define SNN_SPIKE_DECODER_READOUT_EN to add the readout_sel/readout_count debug ports.
module snn_spike_decoder #(
  parameter int  NEURONS     = 8,
  parameter int  COUNT_BITS  = 8,
  parameter int  WINDOW_BITS = 8,
  localparam int IDX_W       = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WINDOW_BITS-1:0] window_len,
  input  logic                   step,
  input  logic [NEURONS-1:0]     spikes,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [IDX_W-1:0]       class_idx,
  output logic [COUNT_BITS-1:0]  class_count,
  output logic                   no_spike
`ifdef SNN_SPIKE_DECODER_READOUT_EN
  ,
  input  logic [IDX_W-1:0]       readout_sel,
  output logic [COUNT_BITS-1:0]  readout_count
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, ARGMAX, DONE} state_t;

  localparam logic [WINDOW_BITS:0]  STEP_ONE  = {{WINDOW_BITS{1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]      IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NEURONS - 1);
  localparam logic [COUNT_BITS-1:0] COUNT_ONE = {{(COUNT_BITS-1){1'b0}}, 1'b1};

  state_t                             state_reg, state_next;
  logic [WINDOW_BITS:0]               target_reg;
  logic [WINDOW_BITS:0]               step_cnt_reg;
  logic [IDX_W-1:0]                   scan_reg;
  logic [NEURONS-1:0][COUNT_BITS-1:0] count_reg;
  logic [NEURONS-1:0][COUNT_BITS-1:0] count_next;
  logic [IDX_W-1:0]                   best_idx_reg;
  logic [COUNT_BITS-1:0]              best_count_reg;
  logic                               no_spike_reg;

  logic                  accept_start;
  logic                  take_step;
  logic                  last_step;
  logic                  last_scan;
  logic                  scan_better;
  logic [COUNT_BITS-1:0] scan_count;

  assign accept_start = (state_reg == IDLE) && start;
  assign take_step    = (state_reg == ACCUM) && step;
  assign last_step    = take_step && ((step_cnt_reg + STEP_ONE) == target_reg);
  assign last_scan    = (state_reg == ARGMAX) && (scan_reg == IDX_LAST);
  assign scan_count   = count_reg[scan_reg];
  // Strict compare keeps the earliest index on ties.
  assign scan_better  = scan_count > best_count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NEURONS; gi++) begin : g_count
      assign count_next[gi] = (spikes[gi] && (count_reg[gi] != '1))
                              ? count_reg[gi] + COUNT_ONE
                              : count_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start)        state_next = ACCUM;
      ACCUM:   if (last_step)    state_next = ARGMAX;
      ARGMAX:  if (last_scan)    state_next = DONE;
      DONE:    if (result_ready) state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg      <= '0;
      step_cnt_reg   <= '0;
      target_reg     <= '0;
      scan_reg       <= '0;
      best_idx_reg   <= '0;
      best_count_reg <= '0;
      no_spike_reg   <= 1'b0;
    end else begin
      if (accept_start) begin
        count_reg      <= '0;
        step_cnt_reg   <= '0;
        // A zero length encodes the full 2^WINDOW_BITS window via the extra MSB.
        target_reg     <= {(window_len == '0), window_len};
        scan_reg       <= '0;
        best_idx_reg   <= '0;
        best_count_reg <= '0;
        no_spike_reg   <= 1'b0;
      end
      if (take_step) begin
        count_reg    <= count_next;
        step_cnt_reg <= step_cnt_reg + STEP_ONE;
      end
      if (state_reg == ARGMAX) begin
        scan_reg <= last_scan ? '0 : scan_reg + IDX_ONE;
        if (scan_better) begin
          best_idx_reg   <= scan_reg;
          best_count_reg <= scan_count;
        end
        if (last_scan) begin
          no_spike_reg <= !scan_better && (best_count_reg == '0);
        end
      end
    end
  end

  assign busy         = (state_reg != IDLE);
  assign result_valid = (state_reg == DONE);
  assign class_idx    = best_idx_reg;
  assign class_count  = best_count_reg;
  assign no_spike     = no_spike_reg;

`ifdef SNN_SPIKE_DECODER_READOUT_EN
  always_comb begin
    readout_count = '0;
    if (int'(readout_sel) < NEURONS) begin
      readout_count = count_reg[readout_sel];
    end
  end
`endif

endmodule

// File: tb/tb_snn_spike_decoder.sv
// Directed bench for snn_spike_decoder: a window-level reference model checked every cycle plus literal expectations.
module tb_snn_spike_decoder;
  localparam int N    = 8;
  localparam int CB   = 8;
  localparam int WB   = 8;
  localparam int CMAX = (1 << CB) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [WB-1:0] window_len = '0;
  logic          step = 1'b0;
  logic [N-1:0]  spikes = '0;
  logic          result_ready = 1'b0;
  logic          busy;
  logic          result_valid;
  logic [2:0]    class_idx;
  logic [CB-1:0] class_count;
  logic          no_spike;
`ifdef SNN_SPIKE_DECODER_READOUT_EN
  logic [2:0]    readout_sel = '0;
  logic [CB-1:0] readout_count;
`endif

  snn_spike_decoder #(.NEURONS(N), .COUNT_BITS(CB), .WINDOW_BITS(WB)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .window_len   (window_len),
    .step         (step),
    .spikes       (spikes),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .class_idx    (class_idx),
    .class_count  (class_count),
    .no_spike     (no_spike)
`ifdef SNN_SPIKE_DECODER_READOUT_EN
    ,
    .readout_sel  (readout_sel),
    .readout_count(readout_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_step_cyc = 0;
  int window_no = 0;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef SNN_SPIKE_DECODER_READOUT_EN
  always @(posedge clk) begin
    #1;
    readout_sel = readout_sel + 3'd1;
  end
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: window bookkeeping by counts and timestamps, not by state machine.
  int m_counts[N];
  bit m_init = 0;
  bit m_busy, m_valid, m_nospike;
  int m_steps_left, m_scan_left, m_idx, m_cnt;

  always @(posedge clk) begin
    if (reset) begin
      m_init = 1;
      m_busy = 0; m_valid = 0; m_nospike = 0;
      m_steps_left = 0; m_scan_left = 0; m_idx = 0; m_cnt = 0;
      foreach (m_counts[i]) m_counts[i] = 0;
    end else if (m_valid) begin
      if (result_ready) begin
        m_valid = 0;
        m_busy  = 0;
      end
    end else if (m_scan_left > 0) begin
      m_scan_left--;
      if (m_scan_left == 0) m_valid = 1;
    end else if (m_steps_left > 0) begin
      if (step) begin
        foreach (m_counts[i])
          if (spikes[i] && m_counts[i] < CMAX) m_counts[i]++;
        m_steps_left--;
        if (m_steps_left == 0) begin
          int total;
          m_idx = 0; m_cnt = 0; total = 0;
          foreach (m_counts[i]) begin
            total += m_counts[i];
            if (m_counts[i] > m_cnt) begin
              m_cnt = m_counts[i];
              m_idx = i;
            end
          end
          m_nospike   = (total == 0);
          m_scan_left = N;
        end
      end
    end else if (!m_busy && start) begin
      m_busy = 1;
      foreach (m_counts[i]) m_counts[i] = 0;
      m_steps_left = (window_len == 0) ? (1 << WB) : int'(window_len);
      m_idx = 0; m_cnt = 0; m_nospike = 0;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("busy", busy, m_busy);
      check("result_valid", result_valid, m_valid);
      if (m_scan_left == 0) begin
        check("class_idx", class_idx, m_idx);
        check("class_count", class_count, m_cnt);
        check("no_spike", no_spike, m_nospike);
      end
`ifdef SNN_SPIKE_DECODER_READOUT_EN
      check("readout_count", readout_count, m_counts[readout_sel]);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int len);
    start = 1'b1;
    window_len = WB'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic do_step(input logic [N-1:0] spk);
    step = 1'b1;
    spikes = spk;
    last_step_cyc = cyc;
    tick();
    step = 1'b0;
    spikes = '0;
  endtask

  task automatic wait_valid(output int rise);
    rise = -1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        rise = cyc;
        break;
      end
    end
    if (rise < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_valid: result_valid low after 600 cycles, required high");
    end else begin
      window_no++;
      $display("window %0d: class_idx=%0d class_count=%0d no_spike=%0d latency=%0d",
               window_no, class_idx, class_count, no_spike, rise - last_step_cyc);
    end
  endtask

  initial begin
    int rise;
    tick(); tick();
    reset = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_valid", result_valid, 0);
    check("reset_class_idx", class_idx, 0);
    check("reset_class_count", class_count, 0);
    check("reset_no_spike", no_spike, 0);

    // Single winner, result_ready held high throughout.
    result_ready = 1'b1;
    do_start(4);
    for (int k = 0; k < 4; k++) do_step(8'b0000_0100);
    wait_valid(rise);
    check("w1_class_idx", class_idx, 2);
    check("w1_class_count", class_count, 4);
    check("w1_no_spike", no_spike, 0);
    check("w1_latency", rise - last_step_cyc, 9);
    tick();
    tick();
    check("w1_idle_busy", busy, 0);
    check("w1_idle_retain_idx", class_idx, 2);

    // No spikes at all.
    do_start(3);
    for (int k = 0; k < 3; k++) do_step(8'h00);
    wait_valid(rise);
    check("w2_no_spike", no_spike, 1);
    check("w2_class_idx", class_idx, 0);
    check("w2_class_count", class_count, 0);
    tick();

    // Tie between neurons 1 and 5; a step alongside start must not count; gaps between steps.
    start = 1'b1; step = 1'b1; spikes = 8'hFF; window_len = 8'd6;
    tick();
    start = 1'b0; step = 1'b0; spikes = '0;
    do_step(8'b0010_0010);
    tick();
    do_step(8'b0010_0011);
    do_step(8'b1010_0010);
    tick();
    do_step(8'b0000_1000);
    do_step(8'b0000_1000);
    do_step(8'b0000_0000);
    wait_valid(rise);
    check("w3_class_idx", class_idx, 1);
    check("w3_class_count", class_count, 3);
    check("w3_latency", rise - last_step_cyc, 9);
    tick();

    // Full 256-step window saturates neuron 7.
    do_start(0);
    for (int k = 0; k < 256; k++) do_step((k < 10) ? 8'h81 : 8'h80);
    wait_valid(rise);
    check("w4_class_idx", class_idx, 7);
    check("w4_class_count", class_count, 255);
    check("w4_latency", rise - last_step_cyc, 9);
    tick();

    // Result held while result_ready is low; start during DONE ignored.
    result_ready = 1'b0;
    do_start(5);
    do_step(8'h50);
    tick();
    do_step(8'h40);
    tick(); tick();
    do_step(8'h10);
    do_step(8'h40);
    do_step(8'h00);
    wait_valid(rise);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        start = 1'b1;
        window_len = 8'd2;
      end
      tick();
      start = 1'b0;
      check("w5_hold_valid", result_valid, 1);
      check("w5_hold_idx", class_idx, 6);
      check("w5_hold_count", class_count, 3);
      check("w5_hold_no_spike", no_spike, 0);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("w5_after_hs_busy", busy, 0);
    check("w5_after_hs_valid", result_valid, 0);
    tick();
    check("w5_idle_busy", busy, 0);

    // Reset mid-accumulation wins over start, step and result_ready.
    do_start(4);
    do_step(8'hFF);
    do_step(8'hFF);
    reset = 1'b1; start = 1'b1; step = 1'b1; spikes = 8'hFF; result_ready = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; step = 1'b0; spikes = '0; result_ready = 1'b0;
    check("w6_reset_busy", busy, 0);
    check("w6_reset_valid", result_valid, 0);
    check("w6_reset_class_count", class_count, 0);
    tick();
    check("w6_idle_busy", busy, 0);

    // Recovery window after reset, tie at count 1.
    result_ready = 1'b1;
    do_start(2);
    do_step(8'h01);
    do_step(8'h02);
    wait_valid(rise);
    check("w7_class_idx", class_idx, 0);
    check("w7_class_count", class_count, 1);
    check("w7_latency", rise - last_step_cyc, 9);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
